decode_stall_ctrl: RTL

Sequencing controller for the decode stage: register file, control unit and IF/ID / ID/EX pipeline registers. Per cycle it decides whether the word in IF/ID is decoded, held, flushed or replaced by a bubble. It covers load-use hazards, two-word immediate instructions, taken-branch flushes and interrupt entry. It replaces the ad-hoc aluSrc feedback into decode with an explicit imm_phase output.

---
 rtl/decode_stall_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stall_ctrl.sv
// Decode-stage sequencing controller.
// Decides each cycle whether the IF/ID word is decoded, held, flushed or
// replaced by a bubble. It covers load-use hazards, two-word immediate
// instructions, taken-branch flushes and interrupt entry.
//
// Handshake note: this block has no valid/ready pairs of its own.
// instr_valid and ex_valid qualify the IF/ID and ID/EX contents. The
// pc_write, ifid_write, ifid_flush and idex_bubble outputs are enables that
// take effect at the next rising clock edge.
module decode_stall_ctrl #(
   parameter int INSTR_W      = 16,
   parameter int RA_W         = 3,
   parameter int FLUSH_CYCLES = 2,
   parameter int INT_CYCLES   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               id_alusrc,
   input  logic               ex_valid,
   input  logic               ex_memr,
   input  logic [RA_W-1:0]    ex_rdst,
   input  logic               branch_taken,
   input  logic               interrupt,
   output logic               pc_write,
   output logic               ifid_write,
   output logic               ifid_flush,
   output logic               idex_bubble,
   output logic               imm_phase,
   output logic               int_push_pc,
   output logic               int_ack,
   output logic [1:0]         state
);

   // Source register fields inside the instruction word.
   localparam int SRC1_LSB = 9;
   localparam int SRC2_LSB = 6;

   // A single counter serves both FLUSH and INT, so it must fit the larger one.
   localparam int CNT_MAX = (FLUSH_CYCLES > INT_CYCLES) ? FLUSH_CYCLES : INT_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      IMM   = 2'd1,
      FLUSH = 2'd2,
      INT   = 2'd3
   } stateT;

   stateT            stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             intPendQ, intPendD;
   logic             intPrevQ;
   logic             intFirstQ, intFirstD;
   logic             intRise;
   logic             hazard;
   logic             ackCycle;
   logic [INSTR_W-1:0] unusedInstr;

   // Only the two source fields matter here; the rest of the word is ignored.
   assign unusedInstr = instruction;

   assign intRise = interrupt & ~intPrevQ;

   // A load in ID/EX writes a register that the word in IF/ID reads.
   assign hazard = instr_valid & ex_valid & ex_memr &
                   ((ex_rdst == instruction[SRC1_LSB +: RA_W]) |
                    (ex_rdst == instruction[SRC2_LSB +: RA_W]));

   assign state = stateQ;

   // Next-state logic and outputs. Branch overrides everything, then the
   // per-state behaviour applies. While reset is held the outputs stay at
   // their reset values.
   always_comb begin
      stateD      = stateQ;
      cntD        = cntQ;
      intFirstD   = intFirstQ;
      ackCycle    = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      imm_phase   = 1'b0;
      int_push_pc = 1'b0;
      int_ack     = 1'b0;

      case (stateQ)
         RUN: begin
            if (intPendQ) begin
               // Freeze fetch and let the held word be decoded after return.
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               stateD      = INT;
               cntD        = CNT_W'(INT_CYCLES - 1);
               intFirstD   = 1'b1;
            end else if (hazard) begin
               // One stall is enough: the bubble then occupies ID/EX.
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end else if (instr_valid && id_alusrc) begin
               stateD = IMM;
            end
         end
         IMM: begin
            imm_phase = 1'b1;
            if (instr_valid) begin
               stateD = RUN;
            end
         end
         FLUSH: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (cntQ == '0) begin
               stateD = RUN;
            end else begin
               cntD = cntQ - CNT_W'(1);
            end
         end
         INT: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            intFirstD  = 1'b0;
            if (intFirstQ) begin
               int_push_pc = 1'b1;
            end else begin
               idex_bubble = 1'b1;
            end
            if (cntQ == '0) begin
               int_ack  = 1'b1;
               ackCycle = 1'b1;
               stateD   = RUN;
            end else begin
               cntD = cntQ - CNT_W'(1);
            end
         end
         default: begin
            stateD = RUN;
         end
      endcase

      // A taken branch cancels IMM and aborts INT. The pending interrupt
      // survives, so the entry sequence restarts later.
      if (branch_taken) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         int_push_pc = 1'b0;
         int_ack     = 1'b0;
         ackCycle    = 1'b0;
         intFirstD   = 1'b0;
         if (FLUSH_CYCLES > 1) begin
            stateD = FLUSH;
            cntD   = CNT_W'(FLUSH_CYCLES - 2);
         end else begin
            stateD = RUN;
            cntD   = '0;
         end
      end

      intPendD = (intPendQ & ~ackCycle) | intRise;

      if (!reset) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
         imm_phase   = 1'b0;
         int_push_pc = 1'b0;
         int_ack     = 1'b0;
      end
   end

   // State, counter and interrupt bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ    <= RUN;
         cntQ      <= '0;
         intPendQ  <= 1'b0;
         intPrevQ  <= 1'b0;
         intFirstQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         intPendQ  <= intPendD;
         intPrevQ  <= interrupt;
         intFirstQ <= intFirstD;
      end
   end

endmodule
